// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and pipeline load/store.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after FETCH_STARVE_LIMIT consecutive losses.
module mem_port_arbiter #(
    parameter int ADDR_BIT_WIDTH     = 32,
    parameter int DATA_BIT_WIDTH     = 32,
    parameter int MEM_LATENCY        = 2,
    parameter int FETCH_STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetchReq,
    input  logic [ADDR_BIT_WIDTH-1:0] fetchAddr,
    output logic [DATA_BIT_WIDTH-1:0] fetchData,
    output logic                      fetchValid,
    output logic                      fetchStall,
    input  logic                      lsIsLoad,
    input  logic                      lsIsStore,
    input  logic [ADDR_BIT_WIDTH-1:0] lsAddr,
    input  logic [DATA_BIT_WIDTH-1:0] lsWrData,
    output logic [DATA_BIT_WIDTH-1:0] lsRdData,
    output logic                      lsDone,
    output logic                      pipeStall,
    output logic [ADDR_BIT_WIDTH-1:0] memAddr,
    output logic [DATA_BIT_WIDTH-1:0] memWrData,
    output logic                      memRdEn,
    output logic                      memWrEn,
    input  logic [DATA_BIT_WIDTH-1:0] memRdData
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LS, S_RESP} state_t;
    typedef enum logic {OWN_FETCH = 1'b0, OWN_LS = 1'b1} owner_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t                    r_state, w_state_nxt;
    owner_t                    r_owner, w_owner_nxt;
    logic [3:0]                r_cnt, w_cnt_nxt;
    logic                      r_isStore, w_isStore_nxt;
    logic [ADDR_BIT_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_BIT_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic [DATA_BIT_WIDTH-1:0] r_fetchData, r_lsRdData;

    logic w_lsReq;
    logic w_forceFetch;
    logic w_grantLs;
    logic w_grantFetch;
    logic w_access;
    logic w_capture;

    assign w_lsReq      = lsIsLoad | lsIsStore;
    assign w_grantLs    = w_lsReq && !w_forceFetch;
    assign w_grantFetch = fetchReq && !w_grantLs;
    assign w_access     = (r_state == S_FETCH) || (r_state == S_LS);
    assign w_capture    = w_access && (r_cnt == '0) && memRdEn;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(FETCH_STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(FETCH_STARVE_LIMIT);

    logic [STARVE_W-1:0] r_starve, w_starve_nxt;

    assign w_forceFetch = fetchReq && (r_starve == STARVE_MAX);

    // Counts only contested LS wins; any fetch grant restarts the window.
    always_comb begin
        w_starve_nxt = r_starve;
        if (r_state == S_IDLE) begin
            if (w_grantFetch) begin
                w_starve_nxt = '0;
            end else if (w_grantLs && fetchReq && (r_starve != STARVE_MAX)) begin
                w_starve_nxt = r_starve + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else begin
            r_starve <= w_starve_nxt;
        end
    end
`else
    assign w_forceFetch = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_isStore_nxt = r_isStore;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = CNT_INIT;
                if (w_grantLs) begin
                    w_state_nxt   = S_LS;
                    w_owner_nxt   = OWN_LS;
                    w_isStore_nxt = lsIsStore && !lsIsLoad;
                    w_addr_nxt    = lsAddr;
                    w_wdata_nxt   = lsWrData;
                end else if (w_grantFetch) begin
                    w_state_nxt   = S_FETCH;
                    w_owner_nxt   = OWN_FETCH;
                    w_isStore_nxt = 1'b0;
                    w_addr_nxt    = fetchAddr;
                    w_wdata_nxt   = '0;
                end
            end
            S_FETCH, S_LS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_FETCH;
            r_cnt       <= '0;
            r_isStore   <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_fetchData <= '0;
            r_lsRdData  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_isStore <= w_isStore_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            if (w_capture) begin
                if (r_owner == OWN_FETCH) begin
                    r_fetchData <= memRdData;
                end else begin
                    r_lsRdData <= memRdData;
                end
            end
        end
    end

    // Memory-side outputs are gated by state so an aborted access drops them at once.
    always_comb begin
        memAddr    = '0;
        memWrData  = '0;
        memRdEn    = 1'b0;
        memWrEn    = 1'b0;
        fetchValid = 1'b0;
        lsDone     = 1'b0;
        unique case (r_state)
            S_FETCH, S_LS: begin
                memAddr = r_addr;
                memRdEn = !((r_owner == OWN_LS) && r_isStore);
                if ((r_owner == OWN_LS) && r_isStore && (r_cnt == '0)) begin
                    memWrEn   = 1'b1;
                    memWrData = r_wdata;
                end
            end
            S_RESP: begin
                fetchValid = (r_owner == OWN_FETCH);
                lsDone     = (r_owner == OWN_LS);
            end
            default: begin
            end
        endcase
    end

    assign fetchData  = r_fetchData;
    assign lsRdData   = r_lsRdData;
    assign fetchStall = fetchReq && !fetchValid;
    assign pipeStall  = w_lsReq && !lsDone;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between instruction fetch and the load/store of the two-stage pipeline.
- Sequences each memory access over MEM_LATENCY cycles and returns read data to the winning requester.
- Drives the pipeline stall while a load or store is pending, so the pipeline register holds that instruction until the memory access completes.

Parameters:
ADDR_BIT_WIDTH, 32, width of all address ports
DATA_BIT_WIDTH, 32, width of all data ports
MEM_LATENCY, 2, number of memory access cycles per transaction; legal range is 1 to 15
FETCH_STARVE_LIMIT, 4, number of consecutive arbitration losses fetch tolerates before a forced grant (used only with ARB_STARVE_GUARD_EN)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous reset, active-high
fetchReq  input  1  fetch request; held until fetchValid is seen
fetchAddr  input  ADDR_BIT_WIDTH  fetch address; stable while fetchReq is high
fetchData  output  DATA_BIT_WIDTH  captured instruction word
fetchValid  output  1  one-cycle completion pulse for fetch
fetchStall  output  1  fetchReq && !fetchValid
lsIsLoad  input  1  load pending in the pipeline register
lsIsStore  input  1  store pending in the pipeline register
lsAddr  input  ADDR_BIT_WIDTH  load/store address (ALU output)
lsWrData  input  DATA_BIT_WIDTH  store data
lsRdData  output  DATA_BIT_WIDTH  captured load data
lsDone  output  1  one-cycle completion pulse for load/store
pipeStall  output  1  stall to the pipeline register
memAddr  output  ADDR_BIT_WIDTH  memory address
memWrData  output  DATA_BIT_WIDTH  memory write data
memRdEn  output  1  memory read enable
memWrEn  output  1  memory write enable
memRdData  input  DATA_BIT_WIDTH  memory read data, valid on the final access cycle

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Reset forces state IDLE, the access counter to 0, the starve counter to 0, and the owner bit to 0.
  - fetchData and lsRdData reset to 0.
  - All of fetchValid, lsDone, memRdEn, memWrEn, memAddr and memWrData are 0 during reset and while in IDLE.
- States: IDLE, FETCH, LS, RESP.
- IDLE arbitration, evaluated at the clock edge:
  - lsReq is defined as lsIsLoad | lsIsStore. If both lsIsLoad and lsIsStore are high, the transaction is treated as a load.
  - lsReq → LS, owner = LS.
  - Otherwise fetchReq → FETCH, owner = FETCH.
  - Otherwise remain in IDLE.
  - The access counter loads MEM_LATENCY-1.
- FETCH and LS states:
  - memAddr is the owner's address; memRdEn = 1 for fetch or load, for every access cycle.
  - For a store, memWrEn = 1 only on the final cycle (counter == 0), with memWrData = lsWrData. memWrData = 0 otherwise.
  - The counter decrements each cycle. When the counter is 0, the state moves to RESP at the next edge, and read data is captured into fetchData or lsRdData per the owner.
  - A store leaves lsRdData unchanged.
- RESP: asserts fetchValid or lsDone per the owner for exactly one cycle, then always → IDLE.
- Latency:
  - A request sampled in IDLE cycle 0 occupies access cycles 1..L and RESP in cycle L+1.
  - The requester must update or deassert its request by cycle L+2 (IDLE).
  - Throughput is one transaction per L+2 cycles.
- pipeStall = lsReq && !(state == RESP && owner == LS). It is combinational, and it is high during arbitration and while fetch owns the port.
- Counter widths: access counter is 4 bits; starve counter is clog2(FETCH_STARVE_LIMIT+1) bits and saturates at the limit.
- Request changes during FETCH, LS or RESP are ignored; addresses are not re-sampled.
- Reset mid-access: the access is aborted immediately, with no write pulse and no completion pulse.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined:
  - In IDLE, when both lsReq and fetchReq are high and LS wins, the starve counter increments.
  - When the starve counter equals FETCH_STARVE_LIMIT, fetch wins instead and the counter clears.
  - Any fetch grant clears the counter.
- Not defined: strict load/store priority; the starve counter and FETCH_STARVE_LIMIT are not implemented.

Test Plan:
- Mid-store reset (L=2): assert reset in the first store access cycle → memWrEn stays 0, lsDone stays 0, state IDLE, and memAddr = 0 in that same cycle.
- Single fetch: fetchAddr=0x40 with memRdData=0xDEADBEEF on cycle 2 → memRdEn high in cycles 1-2, fetchValid=1 and fetchData=0xDEADBEEF in cycle 3, IDLE in cycle 4.
- Simultaneous fetchReq and lsIsLoad at 0x100 → load is served in cycles 1-2 with lsDone in cycle 3 and pipeStall high in cycles 0-2; fetch is then granted and fetchValid arrives in cycle 7.
- Store to 0x200 with lsWrData=0x12345678 → memWrEn high only in cycle 2, memWrData=0x12345678, lsRdData unchanged, lsDone in cycle 3.
- With ARB_STARVE_GUARD_EN, limit=4, and lsIsLoad held high continuously with fetchReq high → the first four arbitrations grant LS and the fifth grants FETCH. Without the macro, fetch is never granted.
- MEM_LATENCY=1 → a single access cycle, memWrEn pulses once, and completion arrives in cycle 2.
